// File: rtl/int_res_mem_arbiter.sv
// Round-robin arbiter that shares one synchronous memory port among NUM_REQ requesters.
// A requester can lock the port for a burst of up to MAX_LOCK granted cycles.
module int_res_mem_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          we,
  input  logic [NUM_REQ-1:0]          lock,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, OPEN, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_n;
  logic                 excl_q, excl_d;

  logic [NUM_REQ-1:0]   elig, excl_mask;
  logic [PTR_W-1:0]     win;
  logic                 win_vld, cont;

  logic [1:0]                rd_vld_q;
  logic [1:0][PTR_W-1:0]     rd_tag_q;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + PTR_W'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    cnt_n     = '0;
    excl_d    = 1'b0;
    win       = '0;
    win_vld   = 1'b0;
    cont      = 1'b0;
    gnt       = '0;
    excl_mask = '0;
    excl_mask[owner_q] = 1'b1;
    elig      = rst ? '0 : req;
    // A force-released owner sits out one cycle, but only if someone else is waiting.
    if (excl_q && ((elig & ~excl_mask) != '0))
      elig = elig & ~excl_mask;

    if (!rst && state_q == LOCKED && req[owner_q] && lock[owner_q]) begin
      cont    = 1'b1;
      win     = owner_q;
      win_vld = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!win_vld && elig[(int'(rr_q) + k) % NUM_REQ]) begin
          win     = PTR_W'((int'(rr_q) + k) % NUM_REQ);
          win_vld = 1'b1;
        end
      end
    end

    if (win_vld) begin
      gnt[win] = 1'b1;
      if (!cont) rr_d = nxt(win);
      if (lock[win]) begin
        cnt_n   = cont ? cnt_q + CNT_W'(1) : CNT_W'(1);
        owner_d = win;
        if (cnt_n >= CNT_W'(MAX_LOCK)) begin
          state_d = OPEN;
          cnt_d   = '0;
          excl_d  = 1'b1;
          rr_d    = nxt(win);
        end else begin
          state_d = LOCKED;
          cnt_d   = cnt_n;
        end
      end else begin
        state_d = OPEN;
        cnt_d   = '0;
      end
    end

    if (req == '0) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      excl_q    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_vld_q  <= '0;
      rd_tag_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      excl_q   <= excl_d;
      mem_en   <= win_vld;
      mem_we   <= win_vld & we[win];
      if (win_vld) begin
        mem_addr  <= addr[int'(win)*ADDR_W +: ADDR_W];
        mem_wdata <= wdata[int'(win)*DATA_W +: DATA_W];
      end
      // Stage 0 aligns with the memory command, stage 1 with the returned data.
      rd_vld_q    <= {rd_vld_q[0], win_vld & ~we[win]};
      rd_tag_q[1] <= rd_tag_q[0];
      rd_tag_q[0] <= win;
    end
  end

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (rd_vld_q[1]) begin
      rvalid[rd_tag_q[1]] = 1'b1;
      rdata               = mem_rdata;
    end
  end
endmodule

// File: tb/tb_int_res_mem_arbiter.sv
// Scoreboard bench: expected memory commands and read returns are queued at grant time
// and retired by a negedge monitor.
module tb_int_res_mem_arbiter;
  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req, we, lock;
  logic [2:0][14:0] addr_p;
  logic [2:0][15:0] wdata_p;
  logic [2:0]       gnt, rvalid;
  logic [15:0]      rdata, mem_wdata, mem_rdata;
  logic             mem_en, mem_we;
  logic [14:0]      mem_addr;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct { int c; logic w; logic [14:0] a; logic [15:0] d; } cmd_t;
  typedef struct { int c; int idx; logic [15:0] d; } rv_t;
  cmd_t cq[$];
  rv_t  rq[$];

  logic [15:0] mem    [0:32767];
  logic [15:0] golden [0:32767];
  logic [14:0] last_a;
  logic [15:0] last_d;

  int_res_mem_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
    .addr(addr_p), .wdata(wdata_p), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_a = '0;
      last_d = '0;
    end else begin
      if (cq.size() > 0 && cq[0].c == cyc) begin
        cmd_t e;
        e = cq.pop_front();
        chk("mem_en", {31'd0, mem_en}, 32'd1);
        chk("mem_we", {31'd0, mem_we}, {31'd0, e.w});
        chk("mem_addr", {17'd0, mem_addr}, {17'd0, e.a});
        chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.d});
        last_a = e.a;
        last_d = e.d;
      end else begin
        chk("mem_en_idle", {31'd0, mem_en}, 32'd0);
        chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
        chk("mem_addr_hold", {17'd0, mem_addr}, {17'd0, last_a});
        chk("mem_wdata_hold", {16'd0, mem_wdata}, {16'd0, last_d});
      end
      if (rq.size() > 0 && rq[0].c == cyc) begin
        rv_t r;
        r = rq.pop_front();
        chk("rvalid", {29'd0, rvalid}, 32'd1 << r.idx);
        chk("rdata", {16'd0, rdata}, {16'd0, r.d});
      end else begin
        chk("rvalid_idle", {29'd0, rvalid}, 32'd0);
      end
    end
  end

  task automatic chk_zero();
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_rvalid", {29'd0, rvalid}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
  endtask

  // Called at posedge+1; holds reset across one edge with requests pending.
  task automatic rst_pulse();
    rst = 1'b1;
    req = 3'b111;
    cq.delete();
    rq.delete();
    #3;
    chk_zero();
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;
  endtask

  task automatic step(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                      input logic [2:0] eg);
    int i;
    req = r; we = w; lock = l;
    #3;
    chk("gnt", {29'd0, gnt}, {29'd0, eg});
    i = (eg == 3'b001) ? 0 : (eg == 3'b010) ? 1 : 2;
    if (eg != '0) begin
      cq.push_back('{c: cyc + 1, w: w[i], a: addr_p[i], d: wdata_p[i]});
      if (w[i]) golden[addr_p[i]] = wdata_p[i];
      else      rq.push_back('{c: cyc + 2, idx: i, d: golden[addr_p[i]]});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(3'b000, 3'b000, 3'b000, 3'b000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 32768; a++) begin
      mem[a]    = a[15:0] ^ 16'h5A5A;
      golden[a] = a[15:0] ^ 16'h5A5A;
    end
    rst = 1'b1; req = '0; we = '0; lock = '0;
    for (int i = 0; i < 3; i++) begin
      addr_p[i]  = 15'h100 + 15'(i);
      wdata_p[i] = 16'hA000 + 16'(i);
    end
    @(posedge clk); @(posedge clk); #1;
    chk_zero();
    rst = 1'b0;

    // single read, granted on the first edge after reset
    addr_p[1] = 15'h0010;
    step(3'b010, 3'b000, 3'b000, 3'b010);
    idle(3);

    // fairness from reset
    rst_pulse();
    step(3'b111, 3'b000, 3'b000, 3'b001);
    step(3'b111, 3'b000, 3'b000, 3'b010);
    step(3'b111, 3'b000, 3'b000, 3'b100);
    step(3'b111, 3'b000, 3'b000, 3'b001);
    step(3'b111, 3'b000, 3'b000, 3'b010);
    step(3'b111, 3'b000, 3'b000, 3'b100);

    // lock held to MAX_LOCK, then forced release to requester 0
    step(3'b011, 3'b000, 3'b010, 3'b001);
    for (int k = 0; k < 16; k++) step(3'b011, 3'b000, 3'b010, 3'b010);
    step(3'b011, 3'b000, 3'b010, 3'b001);
    idle(3);

    // early unlock after 3 locked cycles
    for (int k = 0; k < 3; k++) step(3'b011, 3'b000, 3'b010, 3'b010);
    step(3'b011, 3'b000, 3'b000, 3'b001);
    idle(3);

    // write by 0 then read-back by 2
    addr_p[0] = 15'h5; wdata_p[0] = 16'hBEEF;
    addr_p[2] = 15'h5;
    step(3'b001, 3'b001, 3'b000, 3'b001);
    step(3'b100, 3'b000, 3'b000, 3'b100);
    idle(3);
    chk("readback_model", {16'd0, golden[5]}, 32'h0000BEEF);

    // reset in the cycle after a read grant
    addr_p[1] = 15'h0020;
    step(3'b010, 3'b000, 3'b000, 3'b010);
    rst_pulse();
    idle(3);
    step(3'b111, 3'b000, 3'b000, 3'b001);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
